// File: rtl/i_ddr_align_ctrl_if.sv
// Lane bundle between an i_ddr_align_ctrl instance and the fabric/I_DDR side.
// err_cnt exists only when I_DDR_ALIGN_CTRL_ERR_CNT_EN is defined.
interface i_ddr_align_ctrl_if #(
   parameter int unsigned WIDTH = 8
) ();
   localparam int unsigned OW = $clog2(WIDTH);

   logic             start;
   logic             retrain;
   logic [1:0]       q_in;
   logic             ddr_e;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             locked;
   logic             fail;
   logic [OW-1:0]    offset;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
   logic [15:0]      err_cnt;

   modport slave (
      input  start, retrain, q_in,
      output ddr_e, word, word_valid, locked, fail, offset, err_cnt
   );
   modport master (
      output start, retrain, q_in,
      input  ddr_e, word, word_valid, locked, fail, offset, err_cnt
   );
`else
   modport slave (
      input  start, retrain, q_in,
      output ddr_e, word, word_valid, locked, fail, offset
   );
   modport master (
      output start, retrain, q_in,
      input  ddr_e, word, word_valid, locked, fail, offset
   );
`endif
endinterface

// File: rtl/i_ddr_align_ctrl.sv
// I_DDR lane training and word-alignment controller: slips bit offsets until TRAIN_PATTERN is
// seen MATCH_COUNT frames in a row, then streams aligned words. Optional I_DDR_ALIGN_CTRL_ERR_CNT_EN.
module i_ddr_align_ctrl #(
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hB8,
   parameter int unsigned      MATCH_COUNT   = 4
) (
   input logic               c,
   input logic               r,
   i_ddr_align_ctrl_if.slave bus
);
   localparam int unsigned HW  = 2 * WIDTH;
   localparam int unsigned FW  = WIDTH / 2;
   localparam int unsigned OW  = $clog2(WIDTH);
   localparam int unsigned FCW = (FW > 1) ? $clog2(FW) : 1;

   typedef enum logic [2:0] {StIdle, StFill, StCheck, StSlip, StLocked, StFail} state_e;

   state_e           state_q, state_d;
   // The oldest pair of the 2*WIDTH history only exists right after each shift, so it is not stored.
   logic [HW-3:0]    h_q, h_d;
   logic [HW-1:0]    h_shift;
   logic [FCW-1:0]   fc_q, fc_d;
   logic [3:0]       mc_q, mc_d;
   logic             fill_q, fill_d;
   logic [OW-1:0]    offset_q, offset_d;
   logic [WIDTH-1:0] word_q, word_d, cand;
   logic             wv_q, wv_d;
   logic             en, boundary, restart;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
   logic [15:0]      err_q, err_d;
`endif

   always_comb begin
      en       = (state_q != StIdle);
      h_shift  = {h_q, bus.q_in[0], bus.q_in[1]};
      cand     = WIDTH'(h_shift >> (WIDTH - 32'(offset_q)));
      boundary = en && (fc_q == FCW'(FW - 1));
      restart  = bus.retrain && (state_q == StLocked || state_q == StFail);

      state_d  = state_q;
      h_d      = h_q;
      fc_d     = fc_q;
      mc_d     = mc_q;
      fill_d   = fill_q;
      offset_d = offset_q;
      word_d   = word_q;
      wv_d     = 1'b0;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
      err_d    = err_q;
`endif

      if (en) begin
         h_d  = h_shift[HW-3:0];
         fc_d = boundary ? '0 : fc_q + 1'b1;
      end

      if (!bus.start) begin
         state_d  = StIdle;
         fc_d     = '0;
         mc_d     = '0;
         fill_d   = 1'b0;
         offset_d = '0;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
         err_d    = '0;
`endif
      end else if (restart) begin
         state_d  = StFill;
         mc_d     = '0;
         fill_d   = 1'b0;
         offset_d = '0;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
         err_d    = '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StFill;
               fc_d    = '0;
            end
            StFill: begin
               if (boundary) begin
                  fill_d = ~fill_q;
                  if (fill_q) state_d = StCheck;
               end
            end
            StCheck: begin
               if (boundary) begin
                  if (cand == TRAIN_PATTERN) begin
                     mc_d = mc_q + 4'd1;
                     if (mc_q >= 4'(MATCH_COUNT - 1)) begin
                        mc_d    = 4'(MATCH_COUNT);
                        state_d = StLocked;
                     end
                  end else begin
                     mc_d = '0;
                     if (offset_q == OW'(WIDTH - 1)) begin
                        state_d = StFail;
                     end else begin
                        offset_d = offset_q + 1'b1;
                        state_d  = StSlip;
                     end
                  end
               end
            end
            StSlip: begin
               if (boundary) state_d = StCheck;
            end
            StLocked: begin
               if (boundary) begin
                  word_d = cand;
                  wv_d   = 1'b1;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
                  if (cand != TRAIN_PATTERN && cand != word_q && err_q != 16'hFFFF) begin
                     err_d = err_q + 16'd1;
                  end
`endif
               end
            end
            StFail: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         state_q  <= StIdle;
         h_q      <= '0;
         fc_q     <= '0;
         mc_q     <= '0;
         fill_q   <= 1'b0;
         offset_q <= '0;
         word_q   <= '0;
         wv_q     <= 1'b0;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
         err_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         fc_q     <= fc_d;
         mc_q     <= mc_d;
         fill_q   <= fill_d;
         offset_q <= offset_d;
         word_q   <= word_d;
         wv_q     <= wv_d;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
         err_q    <= err_d;
`endif
      end
   end

   assign bus.ddr_e      = en;
   assign bus.word       = word_q;
   assign bus.word_valid = wv_q;
   assign bus.locked     = (state_q == StLocked);
   assign bus.fail       = (state_q == StFail);
   assign bus.offset     = offset_q;
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
   assign bus.err_cnt    = err_q;
`endif
endmodule

// File: tb/tb_i_ddr_align_ctrl.sv
// Randomised self-checking bench for i_ddr_align_ctrl against a frame-level reference model.
module tb_i_ddr_align_ctrl;
   localparam int unsigned W  = 8;
   localparam logic [7:0]  TP = 8'hB8;
   localparam int          MC = 4;

   localparam int PhIdle = 0, PhFill = 1, PhCheck = 2, PhSlip = 3, PhLocked = 4, PhFail = 5;

   logic clk = 1'b0;
   logic rst;

   i_ddr_align_ctrl_if #(.WIDTH(W)) bus ();

   i_ddr_align_ctrl #(
      .WIDTH        (W),
      .TRAIN_PATTERN(TP),
      .MATCH_COUNT  (MC)
   ) dut (
      .c  (clk),
      .r  (rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: lane phase plus the last 16 received bits, oldest first.
   int         ph, en_cyc, fills, mc, off, m_err;
   logic [7:0] m_word;
   logic       m_wv;
   logic       hist[$];

   // Stimulus source: repeated src_pat words starting src_k bits after a frame boundary.
   int         src_n, src_k, bad_wi, wv_seen;
   logic [7:0] src_pat, bad_val;
   bit         noise;

   function automatic logic src_bit(input int n);
      int t, wi, b;
      logic [7:0] w;
      t  = n - src_k + 64;
      wi = t / 8 - 8;
      b  = t % 8;
      w  = (wi == bad_wi) ? bad_val : src_pat;
      return w[7-b];
   endfunction

   task automatic model_reset();
      ph = PhIdle; en_cyc = 0; fills = 0; mc = 0; off = 0; m_err = 0;
      m_word = '0; m_wv = 1'b0;
      hist.delete();
   endtask

   task automatic model_step(input logic st, input logic rt, input logic [1:0] q);
      bit bnd;
      logic [7:0] cand;
      m_wv = 1'b0;
      if (!st) begin
         ph = PhIdle; off = 0; mc = 0; en_cyc = 0; fills = 0; m_err = 0;
         hist.delete();
         return;
      end
      if (ph == PhIdle) begin
         ph = PhFill; en_cyc = 0; fills = 0;
         return;
      end
      hist.push_back(q[0]);
      hist.push_back(q[1]);
      while (hist.size() > 16) void'(hist.pop_front());
      bnd = (en_cyc % 4) == 3;
      en_cyc++;
      if (rt && (ph == PhLocked || ph == PhFail)) begin
         ph = PhFill; off = 0; mc = 0; fills = 0; m_err = 0;
         return;
      end
      if (!bnd) return;
      cand = '0;
      if (hist.size() == 16) begin
         for (int i = 0; i < 8; i++) cand = {cand[6:0], hist[off+i]};
      end
      case (ph)
         PhFill: begin
            fills++;
            if (fills == 2) ph = PhCheck;
         end
         PhCheck: begin
            if (cand == TP) begin
               mc++;
               if (mc == MC) ph = PhLocked;
            end else begin
               mc = 0;
               if (off < 7) begin
                  off++;
                  ph = PhSlip;
               end else begin
                  ph = PhFail;
               end
            end
         end
         PhSlip: ph = PhCheck;
         PhLocked: begin
            if (cand != TP && cand != m_word && m_err < 65535) m_err++;
            m_word = cand;
            m_wv   = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic compare();
      check_val("ddr_e", 32'(bus.ddr_e), 32'(ph != PhIdle));
      check_val("locked", 32'(bus.locked), 32'(ph == PhLocked));
      check_val("fail", 32'(bus.fail), 32'(ph == PhFail));
      check_val("offset", 32'(bus.offset), 32'(off));
      check_val("word_valid", 32'(bus.word_valid), 32'(m_wv));
      check_val("word", 32'(bus.word), 32'(m_word));
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
      check_val("err_cnt", 32'(bus.err_cnt), 32'(m_err));
`endif
   endtask

   task automatic step(input logic st, input logic rt);
      logic [1:0] q;
      @(negedge clk);
      if (ph != PhIdle) begin
         q = noise ? 2'($urandom) : {src_bit(src_n + 1), src_bit(src_n)};
         src_n += 2;
      end else begin
         q = 2'($urandom);
         src_n = 0;
      end
      bus.start   = st;
      bus.retrain = rt;
      bus.q_in    = q;
      if (rst) model_reset();
      else model_step(st, rt, q);
      @(posedge clk);
      #1;
      compare();
      if (bus.word_valid) wv_seen++;
   endtask

   task automatic run(input int n, input int p_rt, input int p_drop);
      logic st, rt;
      for (int i = 0; i < n; i++) begin
         st = !(p_drop > 0 && $urandom_range(0, p_drop - 1) == 0);
         rt = (p_rt > 0 && $urandom_range(0, p_rt - 1) == 0);
         step(st, rt);
      end
   endtask

   initial begin
      int wi;
      bus.start = 1'b1; bus.retrain = 1'b0; bus.q_in = 2'b00;
      src_n = 0; src_k = 0; src_pat = TP; bad_wi = -1000; bad_val = 8'hB9; noise = 0;
      wv_seen = 0;
      model_reset();

      rst = 1'b1;
      run(3, 0, 0);
      rst = 1'b0;

      // Aligned stream at k=0.
      run(40, 0, 0);
      check_val("k0_locked", 32'(bus.locked), 32'd1);
      check_val("k0_offset", 32'(bus.offset), 32'd0);
      run(8, 0, 0);
      check_val("k0_word", 32'(bus.word), 32'hB8);

      // Same stream at k=3 from a fresh start.
      step(1'b0, 1'b0);
      src_k = 3;
      run(70, 0, 0);
      check_val("k3_locked", 32'(bus.locked), 32'd1);
      check_val("k3_offset", 32'(bus.offset), 32'd3);
      check_val("k3_word", 32'(bus.word), 32'hB8);

      // START dropped for one cycle while locked, then relock.
      step(1'b0, 1'b0);
      check_val("drop_ddr_e", 32'(bus.ddr_e), 32'd0);
      check_val("drop_locked", 32'(bus.locked), 32'd0);
      run(70, 0, 0);
      check_val("relock_offset", 32'(bus.offset), 32'd3);
      check_val("relock_locked", 32'(bus.locked), 32'd1);

      // Constant zero stream exhausts every offset.
      step(1'b0, 1'b0);
      src_pat = 8'h00;
      wv_seen = 0;
      run(90, 0, 0);
      check_val("zero_fail", 32'(bus.fail), 32'd1);
      check_val("zero_offset", 32'(bus.offset), 32'd7);
      check_val("zero_no_wv", 32'(wv_seen), 32'd0);
      step(1'b1, 1'b1);
      check_val("rt_fail", 32'(bus.fail), 32'd0);
      check_val("rt_offset", 32'(bus.offset), 32'd0);
      check_val("rt_ddr_e", 32'(bus.ddr_e), 32'd1);
      run(5, 0, 0);

      // One corrupted word while locked.
      step(1'b0, 1'b0);
      src_pat = TP;
      src_k   = $urandom_range(0, 7);
      run(80, 0, 0);
      check_val("bad_pre_locked", 32'(bus.locked), 32'd1);
      wi = (src_n + 64 - src_k) / 8 - 8;
      bad_wi = wi + 2;
      run(24, 0, 0);
      check_val("bad_locked", 32'(bus.locked), 32'd1);
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
      check_val("bad_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif
      step(1'b1, 1'b1);
      check_val("bad_rt_locked", 32'(bus.locked), 32'd0);
`ifdef I_DDR_ALIGN_CTRL_ERR_CNT_EN
      check_val("bad_rt_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

      // Random mix of patterns, offsets, corruptions, retrains, drops and resets.
      for (int it = 0; it < 25; it++) begin
         src_k   = $urandom_range(0, 7);
         src_pat = ($urandom_range(0, 1) == 0) ? TP : 8'($urandom);
         noise   = ($urandom_range(0, 5) == 0);
         bad_val = 8'($urandom);
         bad_wi  = (src_n + 64 - src_k) / 8 - 8 + int'($urandom_range(2, 20));
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            run(2, 0, 0);
            rst = 1'b0;
         end
         run($urandom_range(20, 150), 16, 48);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/i_ddr_align_ctrl.md
Name: i_ddr_align_ctrl

Overview:
- Training and word-alignment controller for one I_DDR input register.
- Drives the I_DDR enable and collects the 2-bit Q pairs into WIDTH-bit parallel words.
- Searches bit offsets until a known training pattern is received MATCH_COUNT times in a row, then streams aligned words to fabric.
- Sits between the I_DDR primitive and the user receive logic; one instance per DDR input lane.

Parameters:
- WIDTH, 8, deserialised word width; even, 4..16.
- TRAIN_PATTERN, 8'hB8, training word expected once aligned; WIDTH bits, MSB is the oldest bit.
- MATCH_COUNT, 4, consecutive matching frames required for lock; 1..15.

Ports:
- C  input  1  clock, same clock as the I_DDR C.
- R  input  1  synchronous, active-high reset.
- START  input  1  level; 1 = run the lane, 0 = return to IDLE.
- RETRAIN  input  1  pulse; restart training from LOCKED or FAIL.
- Q_IN  input  2  I_DDR Q; Q_IN[0] is the rising-edge bit (older), Q_IN[1] the falling-edge bit.
- DDR_E  output  1  drives I_DDR E.
- WORD  output  WIDTH  aligned word, MSB is the oldest bit.
- WORD_VALID  output  1  one-cycle strobe per frame, asserted only in LOCKED.
- LOCKED  output  1  alignment achieved.
- FAIL  output  1  all offsets tried without lock.
- OFFSET  output  log2(WIDTH)  current bit offset.

Behaviour:
- Reset (R=1 at a C rising edge): state IDLE; DDR_E, WORD, WORD_VALID, LOCKED, FAIL, OFFSET, history, frame counter and match counter all 0. Reset wins over every other input.
- History register H (2*WIDTH bits), updated every cycle DDR_E=1: H <= {H[2W-3:0], Q_IN[0], Q_IN[1]}.
- Frame counter fc counts 0..WIDTH/2-1 while DDR_E=1 and wraps to 0. The frame boundary is the cycle where fc = WIDTH/2-1.
- Candidate word at a boundary: H[2W-1-OFFSET -: W], evaluated after that cycle's shift. A stream whose word starts k bits after the frame boundary aligns at OFFSET=k.
- START=0 in any state: next cycle goes to IDLE, DDR_E=0, LOCKED=0, FAIL=0, OFFSET=0, fc=0.
- States:
  - IDLE: DDR_E=0. START=1 -> FILL, DDR_E=1 from the next cycle, fc=0.
  - FILL: wait 2 frame boundaries so history is full -> CHECK.
  - CHECK: at each boundary compare the candidate with TRAIN_PATTERN.
    - Match: mc++. If mc reaches MATCH_COUNT -> LOCKED.
    - Mismatch with OFFSET<WIDTH-1: mc=0, OFFSET++, -> SLIP.
    - Mismatch with OFFSET=WIDTH-1: -> FAIL.
  - SLIP: discard one frame (one boundary) -> CHECK.
  - LOCKED: LOCKED=1. At each boundary, WORD=candidate and WORD_VALID=1 on the next cycle (latency 1 cycle after the boundary). No automatic unlock. RETRAIN -> FILL with OFFSET=0, mc=0, LOCKED=0.
  - FAIL: FAIL=1, DDR_E stays 1. RETRAIN -> FILL with OFFSET=0, FAIL=0.
- RETRAIN in IDLE, FILL, CHECK or SLIP is ignored. RETRAIN together with START=0: START=0 wins.
- WORD holds its last value between strobes and keeps the last LOCKED word after unlock.
- mc saturates at MATCH_COUNT.

Optional Feature:
- Macro: I_DDR_ALIGN_CTRL_ERR_CNT_EN.
- Defined: adds output ERR_CNT (16 bits). It increments at each LOCKED frame boundary where the candidate equals neither TRAIN_PATTERN nor the previous WORD, and saturates at 16'hFFFF. It clears on R, RETRAIN, and entry to IDLE.
- Not defined: ERR_CNT port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8, TRAIN_PATTERN=8'hB8, MATCH_COUNT=4):
- R=1 for 3 cycles with START=1 -> all outputs 0 and DDR_E=0 while R=1.
- START=1, stream 8'hB8 repeated with k=0 -> LOCKED=1 with OFFSET=0 after 2 FILL frames + 4 CHECK frames; then WORD_VALID every 4 cycles with WORD=8'hB8.
- Same stream with k=3 -> OFFSET steps 0,1,2,3 (one SLIP frame each), then LOCKED=1 with OFFSET=3 and WORD=8'hB8.
- Constant 8'h00 stream -> FAIL=1 with OFFSET=7 and WORD_VALID never asserted. RETRAIN pulse -> FAIL=0, OFFSET=0, FILL re-entered.
- In LOCKED, drop START for 1 cycle -> IDLE next cycle with DDR_E=0, LOCKED=0. Raise START again -> relocks at the same k.
- With I_DDR_ALIGN_CTRL_ERR_CNT_EN defined, inject 1 corrupted word (8'hB9) while LOCKED -> ERR_CNT=1 and LOCKED stays 1. RETRAIN -> ERR_CNT=0.
